// File: rtl/vector_writeback_if.sv
// Handshake and register-file write bus between the vector ALU, the writeback
// stage and the vector register file.
interface vector_writeback_if #(
    parameter int LANE_W = 64,
    parameter int LANES  = 16,
    parameter int ADDR_W = 2
);
    localparam int IN_W  = LANES * LANE_W;
    localparam int REG_W = IN_W / 2;

    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    logic [ADDR_W-1:0] in_dest;
    logic              in_single;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [REG_W-1:0]  wr_data;
    logic              done;
    logic              busy;

    modport master (
        output in_valid, in_data, in_dest, in_single,
        input  in_ready, wr_en, wr_addr, wr_data, done, busy
    );

    modport slave (
        input  in_valid, in_data, in_dest, in_single,
        output in_ready, wr_en, wr_addr, wr_data, done, busy
    );
endinterface

// File: rtl/vector_writeback.sv
// Writes one 1024-bit ALU result into the 512-bit vector register file as a
// low-half write followed by an optional high-half write to the next register.
module vector_writeback #(
    parameter int LANE_W = 64,
    parameter int LANES  = 16,
    parameter int REG_W  = 512,
    parameter int ADDR_W = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    vector_writeback_if.slave bus
);
    localparam int IN_W = LANES * LANE_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } state_t;

    state_t            state_q;
    logic [REG_W-1:0]  hi_q;
    logic [ADDR_W-1:0] dest_q;
    logic              single_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [REG_W-1:0]  wr_data_q;
    logic              done_q;

    logic              transfer_d;
    logic [ADDR_W-1:0] hi_addr_d;

    assign transfer_d = bus.in_valid && (state_q == IDLE);
    assign hi_addr_d  = dest_q + ADDR_W'(1);

    // The low half goes straight into wr_data_q on accept, so only the high
    // half needs to be held for the second write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            hi_q      <= '0;
            dest_q    <= '0;
            single_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    wr_en_q <= 1'b0;
                    done_q  <= 1'b0;
                    if (transfer_d) begin
                        hi_q      <= bus.in_data[IN_W-1:REG_W];
                        dest_q    <= bus.in_dest;
                        single_q  <= bus.in_single;
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= bus.in_dest;
                        wr_data_q <= bus.in_data[REG_W-1:0];
                        done_q    <= bus.in_single;
                        state_q   <= WR_LO;
                    end
                end
                WR_LO: begin
                    if (single_q) begin
                        wr_en_q <= 1'b0;
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= hi_addr_d;
                        wr_data_q <= hi_q;
                        done_q    <= 1'b1;
                        state_q   <= WR_HI;
                    end
                end
                WR_HI: begin
                    wr_en_q <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    wr_en_q <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = (state_q == IDLE);
    assign bus.busy     = (state_q != IDLE);
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.done     = done_q;
endmodule
